// File: rtl/inst_seq.sv
// inst_seq: walks the instruction table one entry at a time and presents each
// valid entry to the cache as a request, holding it while the cache stalls.
// A run stops at the first invalid entry, after the last table entry, or when
// a single request stalls for TIMEOUT consecutive cycles (error). Cycle, hit
// and miss counts are kept per run and saturate at all-ones.
//
// Handshake: cache_req is the valid; !cache_stall is the ready. A request
// completes on a rising edge where cache_req=1 and cache_stall=0. While
// cache_req=1 and the cache stalls, every cache_* field holds steady because
// index only moves on completion.
module inst_seq #(
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] index,
  input  logic             inst_valid,
  input  logic             inst_write,
  input  logic [31:0]      inst_addr,
  input  logic [2:0]       inst_u_b_h_w,
  output logic             cache_req,
  output logic             cache_write,
  output logic [31:0]      cache_addr,
  output logic [2:0]       cache_u_b_h_w,
  output logic [31:0]      cache_din,
  input  logic             cache_stall,
  output logic             done,
  output logic             error,
  output logic [31:0]      cycle_cnt,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  // Stalled edges already seen when the current stalled edge is the last allowed.
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] stall_cnt;

  assign dbg_state = state;

  // Request is live only while running on a valid entry; the rst term drops it
  // the instant reset asserts, before the state register has even settled.
  assign cache_req     = rst && (state == S_RUN) && inst_valid;
  assign cache_write   = cache_req && inst_write;
  assign cache_addr    = cache_req ? inst_addr : 32'd0;
  assign cache_din     = cache_req ? inst_addr : 32'd0;
  assign cache_u_b_h_w = cache_req ? inst_u_b_h_w : 3'd0;

  // Sequencer FSM with index, stall tracking and run statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      index     <= '0;
      stall_cnt <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      cycle_cnt <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            index     <= '0;
            stall_cnt <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cycle_cnt <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
          end
        end
        S_RUN: begin
          if (!inst_valid) begin
            // End-of-table marker: finish without issuing a request.
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
            if (!cache_stall) begin
              // Completion: a request that never stalled counts as a hit.
              stall_cnt <= '0;
              if (stall_cnt == 16'd0) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
              end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
              end
              if (index == IDX_MAX) begin
                // Last table slot: stop here rather than wrap to entry 0.
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                index <= index + 1'b1;
              end
            end else if (stall_cnt >= STALL_LAST) begin
              // The cache never answered; abandon the run at this entry.
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: a combinational instruction table and a responsive
// cache stub driven from tasks, checked against a table-walking reference
// model that predicts final counts, run latency and the request order.
module tb_inst_seq;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [IDX_W-1:0] index;
  logic             inst_valid, inst_write;
  logic [31:0]      inst_addr;
  logic [2:0]       inst_u_b_h_w;
  logic             cache_req, cache_write;
  logic [31:0]      cache_addr, cache_din;
  logic [2:0]       cache_u_b_h_w;
  logic             cache_stall = 1'b0;
  logic             done, error;
  logic [31:0]      cycle_cnt;
  logic [15:0]      hit_cnt, miss_cnt;
  logic [1:0]       dbg_state;

  // Instruction table and per-entry stall script for the cache stub.
  logic        v_t[DEPTH];
  logic        w_t[DEPTH];
  logic [31:0] a_t[DEPTH];
  logic [2:0]  u_t[DEPTH];
  int          s_t[DEPTH];

  // Scoreboard state.
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int e_cyc, e_hit, e_miss, e_idx, e_err, e_lat;
  int got_lat, got_reqs;

  assign inst_valid   = v_t[index];
  assign inst_write   = w_t[index];
  assign inst_addr    = a_t[index];
  assign inst_u_b_h_w = u_t[index];

  inst_seq #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .index(index),
    .inst_valid(inst_valid), .inst_write(inst_write), .inst_addr(inst_addr),
    .inst_u_b_h_w(inst_u_b_h_w), .cache_req(cache_req), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
    .cache_stall(cache_stall), .done(done), .error(error), .cycle_cnt(cycle_cnt),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Fill the table: n_valid valid entries then invalid; stalls in [0, max_stall].
  task automatic fill_table(input int n_valid, input int max_stall);
    for (int i = 0; i < DEPTH; i++) begin
      v_t[i] = (i < n_valid);
      w_t[i] = 1'($urandom_range(0, 1));
      a_t[i] = $urandom;
      u_t[i] = 3'($urandom_range(0, 7));
      s_t[i] = (max_stall == 0) ? 0 : $urandom_range(0, max_stall);
    end
  endtask

  // Reference model: walk the table by its rules and predict the run outcome.
  task automatic model_run();
    exp_q.delete();
    e_cyc = 0; e_hit = 0; e_miss = 0; e_err = 0; e_idx = 0; e_lat = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!v_t[i]) begin
        e_idx = i; e_lat = e_cyc + 2; return;
      end
      if (s_t[i] >= TIMEOUT) begin
        e_cyc += TIMEOUT; e_err = 1; e_idx = i; e_lat = e_cyc + 1; return;
      end
      e_cyc += s_t[i] + 1;
      if (s_t[i] == 0) e_hit++; else e_miss++;
      exp_q.push_back(a_t[i]);
      if (i == DEPTH - 1) begin
        e_idx = i; e_lat = e_cyc + 1;
      end
    end
  endtask

  // Pulse start, then act as the cache until done; checks passthrough and order.
  task automatic do_run(input bit poke);
    logic rq, st;
    int stalled;
    logic [31:0] ea;
    got_lat = -1; got_reqs = 0; stalled = 0;
    @(negedge clk); start = 1'b1; cache_stall = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if ({cycle_cnt, hit_cnt, miss_cnt, error} !== 65'd0) begin
          n_bad++;
          $display("FAIL start_clear got cyc=%0d hit=%0d miss=%0d err=%0b want all 0",
                   cycle_cnt, hit_cnt, miss_cnt, error);
        end
      end
      if (done === 1'b1) begin
        got_lat = k;
        break;
      end
      start = poke && (k == 3);
      cache_stall = cache_req && (stalled < s_t[index]);
      if (cache_req === 1'b1) begin
        got_reqs++;
        n_cmp++;
        if ({cache_write, cache_addr, cache_u_b_h_w, cache_din} !==
            {w_t[index], a_t[index], u_t[index], a_t[index]}) begin
          n_bad++;
          $display("FAIL passthrough idx=%0d got w=%0b a=%h u=%0d d=%h want w=%0b a=%h u=%0d d=%h",
                   index, cache_write, cache_addr, cache_u_b_h_w, cache_din,
                   w_t[index], a_t[index], u_t[index], a_t[index]);
        end
        if (!cache_stall) begin
          n_cmp++;
          ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
          if (cache_addr !== ea) begin
            n_bad++;
            $display("FAIL req_order got addr=%h want %h", cache_addr, ea);
          end
        end
      end else begin
        n_cmp++;
        if ({cache_write, cache_addr, cache_u_b_h_w, cache_din} !== 68'd0) begin
          n_bad++;
          $display("FAIL idle_outputs got a=%h d=%h want 0", cache_addr, cache_din);
        end
      end
      rq = cache_req; st = cache_stall;
      @(posedge clk);
      if (rq) stalled = st ? stalled + 1 : 0;
    end
    start = 1'b0; cache_stall = 1'b0;
    n_cmp++;
    if (got_lat < 0) begin
      n_bad++;
      $display("FAIL run_bound got no done within 3000 cycles want done");
    end
  endtask

  // Compare the finished run against the model (latency, request count, result).
  task automatic check_run(input string name);
    n_cmp++;
    if ({done, error, index, cycle_cnt, hit_cnt, miss_cnt} !==
        {1'b1, 1'(e_err), 4'(e_idx), 32'(e_cyc), 16'(e_hit), 16'(e_miss)}) begin
      n_bad++;
      $display("FAIL %s_result got done=%0b err=%0b idx=%0d cyc=%0d hit=%0d miss=%0d want 1 %0d %0d %0d %0d %0d",
               name, done, error, index, cycle_cnt, hit_cnt, miss_cnt,
               e_err, e_idx, e_cyc, e_hit, e_miss);
    end
    n_cmp++;
    if (got_lat != e_lat || got_reqs != e_cyc || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timing got lat=%0d reqs=%0d left=%0d want lat=%0d reqs=%0d left=0",
               name, got_lat, got_reqs, exp_q.size(), e_lat, e_cyc);
    end
  endtask

  task automatic test_reset();
    fill_table(5, 0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({index, cache_req, done, error, cycle_cnt, hit_cnt, miss_cnt, dbg_state} !== 73'd0) begin
      n_bad++;
      $display("FAIL reset_state got idx=%0d req=%0b done=%0b err=%0b cyc=%0d hit=%0d miss=%0d want all 0",
               index, cache_req, done, error, cycle_cnt, hit_cnt, miss_cnt);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cache_req !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_req got req=%0b done=%0b want 0 0", cache_req, done);
    end
  endtask

  task automatic test_program();
    int tmp, j;
    fill_table(9, 0);
    s_t[0] = 0; s_t[1] = 0; s_t[2] = 0; s_t[3] = 0;
    s_t[4] = 17; s_t[5] = 17; s_t[6] = 17; s_t[7] = 17; s_t[8] = 17 + 34;
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = s_t[i]; s_t[i] = s_t[j]; s_t[j] = tmp;
    end
    model_run();
    do_run(1'b0);
    check_run("program");
    n_cmp++;
    if (index !== 4'd9 || cycle_cnt !== 32'd128 || hit_cnt !== 16'd4 ||
        miss_cnt !== 16'd5 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL program_const got idx=%0d cyc=%0d hit=%0d miss=%0d err=%0b want 9 128 4 5 0",
               index, cycle_cnt, hit_cnt, miss_cnt, error);
    end
  endtask

  task automatic test_restart();
    // Table still holds the previous program; a second start must repeat it.
    model_run();
    do_run(1'b0);
    check_run("restart");
  endtask

  task automatic test_empty();
    fill_table(0, 0);
    model_run();
    do_run(1'b0);
    check_run("empty");
  endtask

  task automatic test_timeout();
    fill_table(DEPTH, 5);
    s_t[2] = 100000;
    model_run();
    do_run(1'b0);
    check_run("timeout");
    n_cmp++;
    if (error !== 1'b1 || index !== 4'd2) begin
      n_bad++;
      $display("FAIL timeout_const got err=%0b idx=%0d want 1 2", error, index);
    end
  endtask

  task automatic test_all_hits();
    fill_table(DEPTH, 0);
    model_run();
    do_run(1'b0);
    check_run("all_hits");
    repeat (4) @(negedge clk);
    n_cmp++;
    if (index !== 4'd15 || cycle_cnt !== 32'd16 || hit_cnt !== 16'd16 ||
        done !== 1'b1 || cache_req !== 1'b0) begin
      n_bad++;
      $display("FAIL no_wrap got idx=%0d cyc=%0d hit=%0d done=%0b req=%0b want 15 16 16 1 0",
               index, cycle_cnt, hit_cnt, done, cache_req);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_table($urandom_range(1, DEPTH), (r % 2 == 0) ? 3 : 12);
      model_run();
      // Odd runs pulse start mid-run; it must be ignored.
      do_run(1'(r % 2));
      check_run("random");
    end
  endtask

  task automatic test_reset_mid();
    fill_table(6, 0);
    s_t[0] = 40;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cache_stall = 1'b1;
    repeat (10) @(negedge clk);
    // Reset lands mid-stall together with a start: reset must win.
    rst = 1'b0; start = 1'b1;
    #1;
    n_cmp++;
    if ({cache_req, index, cycle_cnt, hit_cnt, miss_cnt, done, error} !== 71'd0) begin
      n_bad++;
      $display("FAIL reset_mid got req=%0b idx=%0d cyc=%0d hit=%0d miss=%0d want all 0",
               cache_req, index, cycle_cnt, hit_cnt, miss_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b0; cache_stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (cache_req !== 1'b0 || cycle_cnt !== 32'd0) begin
        n_bad++;
        $display("FAIL post_reset_idle got req=%0b cyc=%0d want 0 0", cache_req, cycle_cnt);
      end
    end
    model_run();
    do_run(1'b0);
    check_run("after_reset");
  endtask

  initial begin
    test_reset();
    test_program();
    test_restart();
    test_empty();
    test_timeout();
    test_all_hits();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
